// File: rtl/pipelined_shifter.sv
// Parametrised pipelined barrel shifter/rotator with valid/ready handshake.
// The log2(WIDTH) shift levels are split LSB-first across STAGES register
// stages; each stage carries partial data, op, remaining shamt, fill and tag.
module pipelined_shifter #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 1,
    parameter int unsigned TAG_W  = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int unsigned L    = $clog2(WIDTH);
    localparam int unsigned LAST = STAGES - 1;
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    localparam logic [2:0] OP_SLL  = 3'b000;
    localparam logic [2:0] OP_SRA  = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_SRA2 = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;

    // Pipeline state, one entry per stage
    logic [WIDTH-1:0] data_q  [STAGES];
    logic [2:0]       op_q    [STAGES];
    logic [L-1:0]     shamt_q [STAGES];
    logic             fill_q  [STAGES];
    logic [TAG_W-1:0] tag_q   [STAGES];
    logic [STAGES-1:0] valid_q;

    // Stage inputs (stage 0 from the ports, stage s from register s-1)
    logic [WIDTH-1:0] src_data  [STAGES];
    logic [2:0]       src_op    [STAGES];
    logic [L-1:0]     src_shamt [STAGES];
    logic             src_fill  [STAGES];
    logic [TAG_W-1:0] src_tag   [STAGES];

    logic [WIDTH-1:0] nxt_data_c  [STAGES];
    logic [L-1:0]     nxt_shamt_c [STAGES];

    // en_c[s]: stage s can load this cycle; en_c[STAGES] is the sink.
    // xfer_c[s]: an entry moves into stage s; xfer_c[STAGES] is the output transfer.
    logic [STAGES:0] en_c;
    logic [STAGES:0] xfer_c;

    function automatic int unsigned level_stage(input int unsigned i);
        return (i * STAGES) / L;
    endfunction

    // One shift/rotate level by k positions
    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                     input logic [2:0]       op,
                                                     input logic             fill,
                                                     input int unsigned      k);
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:          r = d << k;
            OP_SRA, OP_SRA2: r = (d >> k) | (fill ? ~(ONES >> k) : '0);
            OP_SRL:          r = d >> k;
            OP_ROL:          r = (d << k) | (d >> (WIDTH - k));
            OP_ROR:          r = (d >> k) | (d << (WIDTH - k));
            default:         r = d;
        endcase
        return r;
    endfunction

    // All levels owned by stage s, applied LSB-first
    function automatic logic [WIDTH-1:0] apply_stage(input int unsigned      s,
                                                     input logic [WIDTH-1:0] d,
                                                     input logic [2:0]       op,
                                                     input logic [L-1:0]     sh,
                                                     input logic             fill);
        logic [WIDTH-1:0] r;
        r = d;
        for (int unsigned i = 0; i < L; i++) begin
            if (level_stage(i) == s && sh[i]) begin
                r = shift_level(r, op, fill, 32'd1 << i);
            end
        end
        return r;
    endfunction

    // Shamt bits still to be consumed after stage s
    function automatic logic [L-1:0] strip_levels(input int unsigned  s,
                                                  input logic [L-1:0] sh);
        logic [L-1:0] r;
        r = sh;
        for (int unsigned i = 0; i < L; i++) begin
            if (level_stage(i) == s) begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    // Ready/advance chain from the sink back to the input
    always_comb begin
        en_c   = '0;
        xfer_c = '0;
        en_c[STAGES] = out_ready;
        for (int s = int'(LAST); s >= 0; s--) begin
            xfer_c[s+1] = valid_q[s] & en_c[s+1];
            en_c[s]     = ~valid_q[s] | xfer_c[s+1];
        end
        in_ready  = en_c[0] & ~flush & ~reset;
        xfer_c[0] = in_valid & in_ready;
    end

    // Stage input selection and per-stage shift levels
    always_comb begin
        src_data  = '{default: '0};
        src_op    = '{default: '0};
        src_shamt = '{default: '0};
        src_fill  = '{default: 1'b0};
        src_tag   = '{default: '0};
        src_data[0]  = in_data;
        src_op[0]    = in_op;
        src_shamt[0] = in_shamt;
        src_fill[0]  = in_data[WIDTH-1];
        src_tag[0]   = in_tag;
        for (int unsigned s = 1; s < STAGES; s++) begin
            src_data[s]  = data_q[s-1];
            src_op[s]    = op_q[s-1];
            src_shamt[s] = shamt_q[s-1];
            src_fill[s]  = fill_q[s-1];
            src_tag[s]   = tag_q[s-1];
        end
        for (int unsigned s = 0; s < STAGES; s++) begin
            nxt_data_c[s]  = apply_stage(s, src_data[s], src_op[s], src_shamt[s], src_fill[s]);
            nxt_shamt_c[s] = strip_levels(s, src_shamt[s]);
        end
    end

    // Stage registers: load on transfer, hold on stall, clear valid on flush
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                data_q[s]  <= '0;
                op_q[s]    <= '0;
                shamt_q[s] <= '0;
                fill_q[s]  <= 1'b0;
                tag_q[s]   <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                if (flush) begin
                    valid_q[s] <= 1'b0;
                end else if (en_c[s]) begin
                    valid_q[s] <= xfer_c[s];
                end
                if (xfer_c[s]) begin
                    data_q[s]  <= nxt_data_c[s];
                    op_q[s]    <= src_op[s];
                    shamt_q[s] <= nxt_shamt_c[s];
                    fill_q[s]  <= src_fill[s];
                    tag_q[s]   <= src_tag[s];
                end
            end
        end
    end

    assign out_valid = valid_q[LAST];
    assign out_data  = data_q[LAST];
    assign out_tag   = tag_q[LAST];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: directed tests on a 32-bit, 2-stage instance
// and randomized traffic on a WIDTH x STAGES sweep against a reference model.
module tb_pipelined_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [63:0] data;
        logic [63:0] tag;
        int          cyc;
    } exp_t;

    // Reference: whole shift/rotate by (shamt mod w) in plain arithmetic
    function automatic logic [63:0] ref_shift(input int unsigned w, input logic [2:0] op,
                                              input logic [63:0] d_in, input int unsigned shamt);
        logic [63:0]        mask, d, r;
        logic signed [63:0] sd;
        int unsigned        sh;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        d    = d_in & mask;
        sh   = shamt % w;
        case (op)
            3'd0:       r = d << sh;
            3'd1, 3'd3: begin
                sd = d;
                if (d[w-1]) sd = d | ~mask;
                r = sd >>> sh;
            end
            3'd2:       r = d >> sh;
            3'd4:       r = (sh == 0) ? d : ((d << sh) | (d >> (w - sh)));
            3'd5:       r = (sh == 0) ? d : ((d >> sh) | (d << (w - sh)));
            default:    r = d;
        endcase
        return r & mask;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Directed-test instance
    logic        d_reset, d_flush, d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [2:0]  d_in_op;
    logic [4:0]  d_in_shamt, d_in_tag, d_out_tag;
    logic [31:0] d_in_data, d_out_data;

    pipelined_shifter #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut (
        .clk       (clk),
        .reset     (d_reset),
        .flush     (d_flush),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .in_op     (d_in_op),
        .in_shamt  (d_in_shamt),
        .in_data   (d_in_data),
        .in_tag    (d_in_tag),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .out_data  (d_out_data),
        .out_tag   (d_out_tag)
    );

    // One op with out_ready high; checks acceptance, latency, data and tag
    task automatic run_op(input logic [2:0] op, input logic [4:0] sh, input logic [31:0] data,
                          input logic [4:0] tag, input logic [31:0] exp, input string name);
        int lat;
        bit got;
        @(negedge clk);
        d_in_valid = 1'b1; d_in_op = op; d_in_shamt = sh; d_in_data = data; d_in_tag = tag;
        d_out_ready = 1'b1;
        #1;
        check({name, "_in_ready"}, 64'(d_in_ready), 64'd1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            d_in_valid = 1'b0;
            lat++;
            #1;
            if (d_out_valid) got = 1'b1;
        end
        check({name, "_latency"}, 64'(lat), 64'd2);
        check({name, "_data"}, 64'(d_out_data), 64'(exp));
        check({name, "_tag"}, 64'(d_out_tag), 64'(tag));
    endtask

    // Randomized sweep: WIDTH in {8,32,64} x STAGES in {1,2,clog2(WIDTH)}
    for (genvar g = 0; g < 9; g++) begin : cfg
        localparam int unsigned W  = (g < 3) ? 8 : ((g < 6) ? 32 : 64);
        localparam int unsigned S  = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 2 : $clog2(W));
        localparam int unsigned LW = $clog2(W);

        logic          r_reset, r_flush, r_in_valid, r_in_ready, r_out_valid, r_out_ready;
        logic [2:0]    r_in_op;
        logic [LW-1:0] r_in_shamt;
        logic [W-1:0]  r_in_data, r_out_data;
        logic [5:0]    r_in_tag, r_out_tag;
        bit            done = 1'b0;

        pipelined_shifter #(.WIDTH(W), .STAGES(S), .TAG_W(6)) u_dut (
            .clk       (clk),
            .reset     (r_reset),
            .flush     (r_flush),
            .in_valid  (r_in_valid),
            .in_ready  (r_in_ready),
            .in_op     (r_in_op),
            .in_shamt  (r_in_shamt),
            .in_data   (r_in_data),
            .in_tag    (r_in_tag),
            .out_valid (r_out_valid),
            .out_ready (r_out_ready),
            .out_data  (r_out_data),
            .out_tag   (r_out_tag)
        );

        initial begin
            exp_t q[$];
            exp_t e;
            logic acc;
            int   tag_ctr;
            r_reset = 1'b1; r_flush = 1'b0; r_in_valid = 1'b0; r_out_ready = 1'b0;
            r_in_op = '0; r_in_shamt = '0; r_in_data = '0; r_in_tag = '0;
            repeat (2) @(negedge clk);
            r_reset = 1'b0;
            acc     = 1'b1;
            tag_ctr = 0;
            for (int c = 0; c < 1200; c++) begin
                @(negedge clk);
                if (acc || !r_in_valid) begin
                    r_in_valid = ($urandom_range(0, 3) != 0);
                    r_in_op    = 3'($urandom_range(0, 7));
                    r_in_shamt = LW'($urandom());
                    r_in_data  = W'({$urandom(), $urandom()});
                    r_in_tag   = 6'(tag_ctr);
                end
                if (c >= 1140) r_in_valid = 1'b0;
                r_out_ready = (c < 300 || c >= 1140) ? 1'b1 : ($urandom_range(0, 2) != 0);
                r_flush     = (c >= 300 && c < 1140) && ($urandom_range(0, 79) == 0);
                #1;
                if (r_flush) check("rand_flush_in_ready", 64'(r_in_ready), 64'd0);
                if (r_out_valid && r_out_ready) begin
                    check("rand_out_expected", 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check("rand_data", 64'(r_out_data), e.data);
                        check("rand_tag_order", 64'(r_out_tag), e.tag);
                        if (c < 300) check("rand_latency", 64'(c - e.cyc), 64'(S));
                        else         check("rand_latency_min", 64'(c - e.cyc >= int'(S)), 64'd1);
                    end
                end
                if (r_flush) q.delete();
                acc = r_in_valid && r_in_ready;
                if (acc) begin
                    e.data = ref_shift(W, r_in_op, 64'(r_in_data), 32'(r_in_shamt));
                    e.tag  = 64'(r_in_tag);
                    e.cyc  = c;
                    q.push_back(e);
                    tag_ctr++;
                end
            end
            check("rand_drain_empty", 64'(q.size()), 64'd0);
            check("rand_drain_out_valid", 64'(r_out_valid), 64'd0);
            done = 1'b1;
        end
    end

    logic all_done;
    assign all_done = cfg[0].done & cfg[1].done & cfg[2].done & cfg[3].done & cfg[4].done
                    & cfg[5].done & cfg[6].done & cfg[7].done & cfg[8].done;

    initial begin
        int          acc_n, t, nv;
        logic [31:0] hold_data;
        logic [4:0]  hold_tag;
        logic [31:0] td;

        d_reset = 1'b1; d_flush = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b0;
        d_in_op = '0; d_in_shamt = '0; d_in_data = '0; d_in_tag = '0;
        @(negedge clk);
        #1;
        check("reset_in_ready_low", 64'(d_in_ready), 64'd0);
        @(negedge clk);
        d_reset = 1'b0;
        #1;
        check("reset_out_valid", 64'(d_out_valid), 64'd0);
        check("reset_out_data", 64'(d_out_data), 64'd0);
        check("reset_out_tag", 64'(d_out_tag), 64'd0);
        check("reset_in_ready_after", 64'(d_in_ready), 64'd1);

        // Basic ops
        run_op(3'd0, 5'd4, 32'h8000_00F1, 5'd7, 32'h0000_0F10, "sll");
        run_op(3'd1, 5'd4, 32'h8000_00F1, 5'd7, 32'hF800_000F, "sra");
        run_op(3'd2, 5'd4, 32'h8000_00F1, 5'd7, 32'h0800_000F, "srl");
        run_op(3'd4, 5'd4, 32'h8000_00F1, 5'd7, 32'h0000_0F18, "rol");
        run_op(3'd5, 5'd4, 32'h8000_00F1, 5'd7, 32'h1800_000F, "ror");
        run_op(3'd6, 5'd4, 32'h8000_00F1, 5'd7, 32'h8000_00F1, "rsvd");

        // Edge amounts
        for (int op = 0; op < 8; op++) begin
            run_op(3'(op), 5'd0, 32'hDEAD_BEEF, 5'(op), 32'hDEAD_BEEF, "shamt0");
        end
        run_op(3'd1, 5'd31, 32'hDEAD_BEEF, 5'd20, 32'hFFFF_FFFF, "sra31");
        run_op(3'd3, 5'd31, 32'hDEAD_BEEF, 5'd21, 32'hFFFF_FFFF, "sra2_31");
        run_op(3'd2, 5'd31, 32'hDEAD_BEEF, 5'd22, 32'h0000_0001, "srl31");
        run_op(3'd4, 5'd31, 32'hDEAD_BEEF, 5'd23, 32'hEF56_DF77, "rol31");
        run_op(3'd5, 5'd31, 32'hDEAD_BEEF, 5'd24, 32'hBD5B_7DDF, "ror31");

        // Back-pressure: only two entries fit, head stays stable
        t = 1;
        acc_n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            d_out_ready = 1'b0; d_in_valid = 1'b1; d_in_op = 3'd5;
            d_in_shamt = 5'(t); d_in_data = 32'(32'h1111_1111 * t); d_in_tag = 5'(t);
            #1;
            if (k == 2) begin
                hold_data = d_out_data;
                hold_tag  = d_out_tag;
                check("bp_head_tag", 64'(d_out_tag), 64'd1);
                check("bp_head_data", 64'(d_out_data), ref_shift(32, 3'd5, 64'h1111_1111, 1));
            end
            if (d_in_ready) begin
                acc_n++;
                t++;
            end
        end
        check("bp_accepted", 64'(acc_n), 64'd2);
        check("bp_in_ready", 64'(d_in_ready), 64'd0);
        check("bp_out_valid", 64'(d_out_valid), 64'd1);
        check("bp_data_stable", 64'(d_out_data), 64'(hold_data));
        check("bp_tag_stable", 64'(d_out_tag), 64'(hold_tag));
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            d_out_ready = 1'b1; d_in_valid = (t <= 4);
            d_in_shamt = 5'(t); d_in_data = 32'(32'h1111_1111 * t); d_in_tag = 5'(t);
            #1;
            if (j < 2) check("bp_no_bubble_ready", 64'(d_in_ready), 64'd1);
            if (j < 4) begin
                td = 32'(32'h1111_1111 * (j + 1));
                check("bp_retire_valid", 64'(d_out_valid), 64'd1);
                check("bp_retire_tag", 64'(d_out_tag), 64'(j + 1));
                check("bp_retire_data", 64'(d_out_data), ref_shift(32, 3'd5, 64'(td), 32'(j + 1)));
            end else begin
                check("bp_empty", 64'(d_out_valid), 64'd0);
            end
            if (d_in_valid && d_in_ready) t++;
        end

        // Flush with two ops in flight
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            d_out_ready = 1'b0; d_in_valid = 1'b1; d_in_op = 3'd0;
            d_in_shamt = 5'(j + 1); d_in_data = 32'hA5A5_0000; d_in_tag = 5'(10 + j);
            #1;
            check("fl_accept", 64'(d_in_ready), 64'd1);
        end
        @(negedge clk);
        d_flush = 1'b1; d_in_tag = 5'd12;
        #1;
        check("fl_in_ready", 64'(d_in_ready), 64'd0);
        @(negedge clk);
        d_flush = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b1;
        nv = 0;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) @(negedge clk);
            #1;
            if (d_out_valid) nv++;
        end
        check("fl_no_out", 64'(nv), 64'd0);
        run_op(3'd2, 5'd8, 32'hCAFE_F00D, 5'd13, 32'h00CA_FEF0, "fl_next");

        // Reset with two ops in flight
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            d_out_ready = 1'b0; d_in_valid = 1'b1; d_in_op = 3'd1;
            d_in_shamt = 5'(j + 3); d_in_data = 32'h9000_0001; d_in_tag = 5'(15 + j);
            #1;
            check("rst_accept", 64'(d_in_ready), 64'd1);
        end
        @(negedge clk);
        d_reset = 1'b1;
        #1;
        check("rst_in_ready", 64'(d_in_ready), 64'd0);
        @(negedge clk);
        d_reset = 1'b0; d_in_valid = 1'b0;
        #1;
        check("rst_out_valid", 64'(d_out_valid), 64'd0);
        check("rst_out_data", 64'(d_out_data), 64'd0);
        check("rst_out_tag", 64'(d_out_tag), 64'd0);
        check("rst_in_ready_after", 64'(d_in_ready), 64'd1);
        run_op(3'd4, 5'd16, 32'h1234_5678, 5'd14, 32'h5678_1234, "rst_next");

        for (int k = 0; k < 3000 && !all_done; k++) @(negedge clk);
        check("rand_done", 64'(all_done), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
